// File: rtl/ar_multi_channel_buffer.sv
// ar_multi_channel_buffer: per-source AR FIFOs, round-robin/QoS arbiter, outstanding-read cap, registered AR output.
module ar_multi_channel_buffer #(
   parameter int NUM_CH          = 4,
   parameter int ID_WIDTH        = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int LEN_WIDTH       = 8,
   parameter int TAG_WIDTH       = 4,
   parameter int FIFO_DEPTH      = 8,
   parameter int MAX_OUTSTANDING = 16,
   parameter int ARB_MODE        = 0,
   localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CH-1:0]              in_valid,
   output logic [NUM_CH-1:0]              in_ready,
   input  logic [NUM_CH*ID_WIDTH-1:0]     in_id,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]   in_addr,
   input  logic [NUM_CH*LEN_WIDTH-1:0]    in_len,
   input  logic [NUM_CH*3-1:0]            in_size,
   input  logic [NUM_CH*2-1:0]            in_burst,
   input  logic [NUM_CH*4-1:0]            in_qos,
   input  logic [NUM_CH*TAG_WIDTH-1:0]    in_tagid,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ID_WIDTH-1:0]            out_id,
   output logic [ADDR_WIDTH-1:0]          out_addr,
   output logic [LEN_WIDTH-1:0]           out_len,
   output logic [2:0]                     out_size,
   output logic [1:0]                     out_burst,
   output logic [3:0]                     out_qos,
   output logic [TAG_WIDTH-1:0]           out_tagid,
   output logic [CH_W-1:0]                out_ch,
   input  logic                           cpl_valid,
   output logic [OUT_W-1:0]               outstanding,
   output logic                           err_underflow
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int REQ_W = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 3 + 2 + 4 + TAG_WIDTH;

   logic [REQ_W-1:0] mem_q [NUM_CH][FIFO_DEPTH];
   logic [REQ_W-1:0] req_in [NUM_CH];
   logic [REQ_W-1:0] head [NUM_CH];
   logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
   logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
   logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
   logic [PTR_W-1:0] rd_ptr_d [NUM_CH];
   logic [CNT_W-1:0] cnt_q [NUM_CH];
   logic [CNT_W-1:0] cnt_d [NUM_CH];
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop;
   logic [REQ_W-1:0] out_q, out_d;
   logic [CH_W-1:0]  out_ch_q, out_ch_d, rr_q, rr_d, grant;
   logic             out_valid_q, out_valid_d, err_q, err_d, grant_v, issue;
   logic [OUT_W-1:0] outstanding_q, outstanding_d;
   logic [3:0]       best, q;
   int               idx;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         req_in[c] = {in_id[c*ID_WIDTH +: ID_WIDTH], in_addr[c*ADDR_WIDTH +: ADDR_WIDTH],
                      in_len[c*LEN_WIDTH +: LEN_WIDTH], in_size[c*3 +: 3], in_burst[c*2 +: 2],
                      in_qos[c*4 +: 4], in_tagid[c*TAG_WIDTH +: TAG_WIDTH]};
         head[c] = mem_q[c][rd_ptr_q[c]];
         in_ready[c] = cnt_q[c] != CNT_W'(FIFO_DEPTH);
         push[c] = in_valid[c] && in_ready[c];
      end
   end

   // Scan from rr_q so a strict '>' leaves ties with the first channel in round-robin order.
   always_comb begin
      grant_v = 1'b0;
      grant = '0;
      best = '0;
      idx = 0;
      q = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = (int'(rr_q) + k) % NUM_CH;
         q = (ARB_MODE != 0) ? head[idx][TAG_WIDTH +: 4] : 4'd0;
         if (cnt_q[idx] != '0 && (!grant_v || q > best)) begin
            grant_v = 1'b1;
            grant = CH_W'(idx);
            best = q;
         end
      end
      issue = grant_v && (!out_valid_q || out_ready) &&
              (outstanding_q < OUT_W'(MAX_OUTSTANDING) || cpl_valid);
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         pop[c] = issue && grant == CH_W'(c);
         wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(push[c]);
         rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(pop[c]);
         cnt_d[c] = cnt_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
      end
   end

   always_comb begin
      out_d = issue ? head[grant] : out_q;
      out_ch_d = issue ? grant : out_ch_q;
      out_valid_d = issue || (out_valid_q && !out_ready);
      rr_d = issue ? ((grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1) : rr_q;
      outstanding_d = (issue && !cpl_valid) ? outstanding_q + 1'b1 :
                      (!issue && cpl_valid && outstanding_q != '0) ? outstanding_q - 1'b1 : outstanding_q;
      err_d = err_q || (cpl_valid && outstanding_q == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
            cnt_q[c] <= '0;
         end
         out_q <= '0;
         out_ch_q <= '0;
         out_valid_q <= 1'b0;
         rr_q <= '0;
         outstanding_q <= '0;
         err_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q <= cnt_d;
         out_q <= out_d;
         out_ch_q <= out_ch_d;
         out_valid_q <= out_valid_d;
         rr_q <= rr_d;
         outstanding_q <= outstanding_d;
         err_q <= err_d;
      end
   end

   // Payload storage carries no reset; validity lives entirely in the pointers and counts.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++)
         if (push[c]) mem_q[c][wr_ptr_q[c]] <= req_in[c];
   end

   assign {out_id, out_addr, out_len, out_size, out_burst, out_qos, out_tagid} = out_q;
   assign out_ch = out_ch_q;
   assign out_valid = out_valid_q;
   assign outstanding = outstanding_q;
   assign err_underflow = err_q;
endmodule

// File: tb/tb_ar_multi_channel_buffer.sv
// tb_ar_multi_channel_buffer: directed and randomized AR traffic checked against a queue-based reference model.
module tb_ar_multi_channel_buffer;
   localparam int N = 4, IDW = 4, AW = 32, LW = 8, TW = 4, D = 8, MO = 4, ARB = 1;
   localparam int CHW = 2, OW = $clog2(MO + 1);

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [AW-1:0]  addr;
      logic [LW-1:0]  len;
      logic [2:0]     size;
      logic [1:0]     burst;
      logic [3:0]     qos;
      logic [TW-1:0]  tag;
      logic [CHW-1:0] ch;
   } req_t;

   typedef struct {
      string            name;
      logic [63:0]      act;
      logic [63:0]      exp;
   } dchk_t;

   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] in_valid = '0, in_ready;
   logic [N*IDW-1:0] in_id = '0;
   logic [N*AW-1:0] in_addr = '0;
   logic [N*LW-1:0] in_len = '0;
   logic [N*3-1:0] in_size = '0;
   logic [N*2-1:0] in_burst = '0;
   logic [N*4-1:0] in_qos = '0;
   logic [N*TW-1:0] in_tagid = '0;
   logic out_valid, out_ready = 1'b0, cpl_valid = 1'b0, err_underflow;
   logic [IDW-1:0] out_id;
   logic [AW-1:0] out_addr;
   logic [LW-1:0] out_len;
   logic [2:0] out_size;
   logic [1:0] out_burst;
   logic [3:0] out_qos;
   logic [TW-1:0] out_tagid;
   logic [CHW-1:0] out_ch;
   logic [OW-1:0] outstanding;

   ar_multi_channel_buffer #(
      .NUM_CH(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
      .FIFO_DEPTH(D), .MAX_OUTSTANDING(MO), .ARB_MODE(ARB)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
      .in_addr(in_addr), .in_len(in_len), .in_size(in_size), .in_burst(in_burst),
      .in_qos(in_qos), .in_tagid(in_tagid), .out_valid(out_valid), .out_ready(out_ready),
      .out_id(out_id), .out_addr(out_addr), .out_len(out_len), .out_size(out_size),
      .out_burst(out_burst), .out_qos(out_qos), .out_tagid(out_tagid), .out_ch(out_ch),
      .cpl_valid(cpl_valid), .outstanding(outstanding), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   req_t  mq [N][$];
   req_t  exq [$];
   int    hs_log [$];
   dchk_t dq [$];
   bit    mv, merr, m_iss;
   int    mo, rr, m_g, m_c;
   bit [N-1:0] m_rdy;
   int    sb_rd, dq_rd;
   int    checks = 0, passes = 0;

   function automatic req_t in_req(input int c);
      req_t r;
      r.id = in_id[c*IDW +: IDW];
      r.addr = in_addr[c*AW +: AW];
      r.len = in_len[c*LW +: LW];
      r.size = in_size[c*3 +: 3];
      r.burst = in_burst[c*2 +: 2];
      r.qos = in_qos[c*4 +: 4];
      r.tag = in_tagid[c*TW +: TW];
      r.ch = CHW'(c);
      return r;
   endfunction

   function automatic int qv(input req_t r);
      return (ARB != 0) ? int'(r.qos) : 0;
   endfunction

   // Reference model: per-channel queues, spec-level arbitration and outstanding accounting.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < N; c++) mq[c].delete();
         exq.delete();
         mv = 0; merr = 0; mo = 0; rr = 0;
      end else begin
         for (int c = 0; c < N; c++) m_rdy[c] = mq[c].size() < D;
         m_g = -1;
         for (int k = 0; k < N; k++) begin
            m_c = (rr + k) % N;
            if (mq[m_c].size() > 0 && (m_g < 0 || qv(mq[m_c][0]) > qv(mq[m_g][0]))) m_g = m_c;
         end
         m_iss = m_g >= 0 && (!mv || out_ready) && (mo < MO || cpl_valid);
         if (cpl_valid && mo == 0) merr = 1;
         if (m_iss) begin
            exq.push_back(mq[m_g].pop_front());
            mv = 1;
            rr = (m_g + 1) % N;
         end else if (mv && out_ready) mv = 0;
         if (m_iss && !cpl_valid) mo++;
         else if (!m_iss && cpl_valid && mo > 0) mo--;
         for (int c = 0; c < N; c++)
            if (in_valid[c] && m_rdy[c]) mq[c].push_back(in_req(c));
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      while (dq_rd < dq.size()) begin
         chk(dq[dq_rd].name, dq[dq_rd].act, dq[dq_rd].exp);
         dq_rd++;
      end
      if (!rst) sb_rd = 0;
      else begin
         chk("out_valid", 64'(out_valid), 64'(mv));
         chk("outstanding", 64'(outstanding), 64'(mo));
         chk("err_underflow", 64'(err_underflow), 64'(merr));
         for (int c = 0; c < N; c++) chk("in_ready", 64'(in_ready[c]), 64'(mq[c].size() < D));
         if (out_valid) begin
            if (sb_rd >= exq.size()) begin
               checks++;
               $display("FAIL out_req: out_valid=1 with no expected request pending");
            end else begin
               chk("out_req", 64'({out_id, out_addr, out_len, out_size, out_burst, out_qos, out_tagid, out_ch}),
                   64'(exq[sb_rd]));
               if (out_ready) begin
                  hs_log.push_back(int'(out_ch));
                  sb_rd++;
               end
            end
         end
      end
   end

   task automatic post(input string name, input logic [63:0] act, input logic [63:0] exp);
      dq.push_back('{name, act, exp});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int c, input logic [IDW-1:0] id, input logic [AW-1:0] a,
                          input logic [LW-1:0] l, input logic [3:0] q);
      in_id[c*IDW +: IDW] = id;
      in_addr[c*AW +: AW] = a;
      in_len[c*LW +: LW] = l;
      in_size[c*3 +: 3] = 3'($urandom);
      in_burst[c*2 +: 2] = 2'($urandom);
      in_qos[c*4 +: 4] = q;
      in_tagid[c*TW +: TW] = TW'($urandom);
   endtask

   task automatic drain();
      in_valid = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         cpl_valid = mo > 0;
         step();
      end
      cpl_valid = 1'b0;
      post("drain_valid", 64'(out_valid), 64'(0));
      post("drain_outstanding", 64'(outstanding), 64'(0));
   endtask

   task automatic async_reset();
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      post("rst_out_valid", 64'(out_valid), 64'(0));
      post("rst_in_ready", 64'(in_ready), 64'(4'hF));
      post("rst_outstanding", 64'(outstanding), 64'(0));
      in_valid = '0;
      cpl_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
   endtask

   int base, acc;
   int qos_exp [4] = '{1, 2, 0, 3};

   initial begin
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      post("reset_out_valid", 64'(out_valid), 64'(0));
      post("reset_in_ready", 64'(in_ready), 64'(4'hF));
      post("reset_outstanding", 64'(outstanding), 64'(0));
      post("reset_err", 64'(err_underflow), 64'(0));
      post("reset_fields", 64'({out_id, out_addr, out_len, out_qos, out_ch}), 64'(0));
      #2 rst = 1'b1;
      step();

      out_ready = 1'b1;
      set_req(0, 4'd3, 32'h1000, 8'd7, 4'd0);
      in_valid = 4'b0001;
      step();
      in_valid = '0;
      post("single_latency1", 64'(out_valid), 64'(0));
      step();
      post("single_valid", 64'(out_valid), 64'(1));
      post("single_id", 64'(out_id), 64'(3));
      post("single_addr", 64'(out_addr), 64'(32'h1000));
      post("single_len", 64'(out_len), 64'(7));
      post("single_ch", 64'(out_ch), 64'(0));
      post("single_outstanding", 64'(outstanding), 64'(1));
      drain();

      async_reset();
      out_ready = 1'b0;
      base = hs_log.size();
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < N; c++) set_req(c, IDW'($urandom), $urandom, LW'($urandom), 4'd2);
         in_valid = '1;
         step();
      end
      drain();
      for (int i = 0; i < 8; i++)
         post("rr_order", 64'((hs_log.size() > base + i) ? hs_log[base + i] : -1), 64'(i % 4));

      async_reset();
      out_ready = 1'b1;
      base = hs_log.size();
      set_req(0, 4'd0, 32'h100, 8'd0, 4'd1);
      set_req(1, 4'd1, 32'h200, 8'd1, 4'd5);
      set_req(2, 4'd2, 32'h300, 8'd2, 4'd5);
      set_req(3, 4'd3, 32'h400, 8'd3, 4'd0);
      in_valid = '1;
      step();
      drain();
      for (int i = 0; i < 4; i++)
         post("qos_order", 64'((hs_log.size() > base + i) ? hs_log[base + i] : -1), 64'(qos_exp[i]));

      async_reset();
      out_ready = 1'b0;
      base = hs_log.size();
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         set_req(2, IDW'(i), $urandom, LW'($urandom), 4'($urandom));
         in_valid = 4'b0100;
         if (in_ready[2]) acc++;
         step();
      end
      in_valid = '0;
      post("full_accepts", 64'(acc), 64'(D + 1));
      post("full_in_ready", 64'(in_ready[2]), 64'(0));
      drain();
      post("full_issued", 64'(hs_log.size() - base), 64'(D + 1));

      async_reset();
      out_ready = 1'b1;
      base = hs_log.size();
      for (int i = 0; i < 6; i++) begin
         set_req(1, IDW'(i), $urandom, LW'($urandom), 4'd0);
         in_valid = 4'b0010;
         step();
      end
      in_valid = '0;
      repeat (6) step();
      post("cap_issued", 64'(hs_log.size() - base), 64'(MO));
      post("cap_outstanding", 64'(outstanding), 64'(MO));
      post("cap_stalled", 64'(out_valid), 64'(0));
      cpl_valid = 1'b1;
      step();
      cpl_valid = 1'b0;
      repeat (4) step();
      post("cap_after_cpl", 64'(hs_log.size() - base), 64'(MO + 1));
      post("cap_outstanding2", 64'(outstanding), 64'(MO));
      drain();

      async_reset();
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < N; c++) set_req(c, IDW'($urandom), $urandom, LW'($urandom), 4'($urandom_range(0, 3)));
         in_valid = N'($urandom);
         out_ready = $urandom_range(0, 9) < 7;
         cpl_valid = (mo > 0) && ($urandom_range(0, 2) == 0);
         step();
      end
      drain();

      out_ready = 1'b0;
      for (int c = 0; c < N; c++) set_req(c, IDW'($urandom), $urandom, LW'($urandom), 4'd1);
      in_valid = '1;
      step();
      step();
      in_valid = '0;
      post("pre_rst_valid", 64'(out_valid), 64'(1));
      async_reset();
      base = hs_log.size();
      out_ready = 1'b1;
      repeat (5) step();
      post("post_rst_idle", 64'(out_valid), 64'(0));
      post("post_rst_no_issue", 64'(hs_log.size() - base), 64'(0));

      cpl_valid = 1'b1;
      step();
      cpl_valid = 1'b0;
      step();
      post("underflow_err", 64'(err_underflow), 64'(1));
      post("underflow_cnt", 64'(outstanding), 64'(0));

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
